// File: rtl/mcu_spi_link.sv
// SPI slave link between the board MCU and the core: deserialises MCU frames,
// routes bytes to one of four command targets and returns their replies on MISO.
//
//  state  | meaning
//  IDLE   | chip select released, waiting for a fresh select
//  TARGET | receiving the target-select byte
//  CMD    | receiving the command byte (strobed with mcu_start = 1)
//  DATA   | receiving payload bytes (strobed with mcu_start = 0)
module mcu_spi_link #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       spi_io_ss,
   input  logic       spi_io_clk,
   input  logic       spi_io_din,
   output logic       spi_io_dout,
   output logic       mcu_sys_strobe,
   output logic       mcu_hid_strobe,
   output logic       mcu_osd_strobe,
   output logic       mcu_sdc_strobe,
   output logic       mcu_start,
   output logic [7:0] mcu_dout,
   input  logic [7:0] mcu_sys_din,
   input  logic [7:0] mcu_hid_din,
   input  logic [7:0] mcu_osd_din,
   input  logic [7:0] mcu_sdc_din,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, TARGET, CMD, DATA} state_t;
   typedef enum logic [2:0] {
      TGT_SYS  = 3'd0,
      TGT_HID  = 3'd1,
      TGT_OSD  = 3'd2,
      TGT_SDC  = 3'd3,
      TGT_NONE = 3'd4
   } tgt_t;

   logic [SYNC_STAGES-1:0] ss_sync_q, sck_sync_q, din_sync_q;
   logic       ss_s, sck_s, din_s;
   logic       ss_prev_q, sck_prev_q;
   logic       sck_rise, sck_fall, ss_fall;
   state_t     state_q;
   tgt_t       tgt_q, tgt_d;
   logic [7:0] rx_q, rx_d, tx_q, dout_q, reply_d;
   logic [2:0] bitcnt_q;
   logic       done_q, load_pend_q;
   logic [3:0] strobe_q;
   logic       start_q, busy_q;

   assign ss_s  = ss_sync_q[SYNC_STAGES-1];
   assign sck_s = sck_sync_q[SYNC_STAGES-1];
   assign din_s = din_sync_q[SYNC_STAGES-1];

   assign sck_rise = sck_s & ~sck_prev_q;
   assign sck_fall = ~sck_s & sck_prev_q;
   // ss_prev_q resets low so a select already active at reset release never opens a frame
   assign ss_fall  = ss_prev_q & ~ss_s;

   assign rx_d  = {rx_q[6:0], din_s};
   assign tgt_d = (rx_q[7:2] == 6'd0) ? tgt_t'({1'b0, rx_q[1:0]}) : TGT_NONE;

   always_comb begin
      reply_d = 8'h00;
      if (state_q == DATA) begin
         case (tgt_q)
            TGT_SYS: reply_d = mcu_sys_din;
            TGT_HID: reply_d = mcu_hid_din;
            TGT_OSD: reply_d = mcu_osd_din;
            TGT_SDC: reply_d = mcu_sdc_din;
            default: reply_d = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ss_sync_q   <= '0;
         sck_sync_q  <= '0;
         din_sync_q  <= '0;
         ss_prev_q   <= 1'b0;
         sck_prev_q  <= 1'b0;
         state_q     <= IDLE;
         tgt_q       <= TGT_NONE;
         rx_q        <= 8'h00;
         tx_q        <= 8'h00;
         dout_q      <= 8'h00;
         bitcnt_q    <= 3'd0;
         done_q      <= 1'b0;
         load_pend_q <= 1'b0;
         strobe_q    <= 4'b0000;
         start_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         ss_sync_q  <= {ss_sync_q[SYNC_STAGES-2:0], spi_io_ss};
         sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], spi_io_clk};
         din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], spi_io_din};
         ss_prev_q  <= ss_s;
         sck_prev_q <= sck_s;
         strobe_q   <= 4'b0000;
         start_q    <= 1'b0;
         done_q     <= 1'b0;

         if (ss_s) begin
            state_q     <= IDLE;
            tgt_q       <= TGT_NONE;
            bitcnt_q    <= 3'd0;
            tx_q        <= 8'h00;
            load_pend_q <= 1'b0;
            busy_q      <= 1'b0;
         end else if (state_q == IDLE) begin
            if (ss_fall) begin
               state_q     <= TARGET;
               tgt_q       <= TGT_NONE;
               bitcnt_q    <= 3'd0;
               rx_q        <= 8'h00;
               tx_q        <= 8'h00;
               load_pend_q <= 1'b0;
               busy_q      <= 1'b1;
            end
         end else begin
            busy_q <= 1'b1;
            if (sck_rise) begin
               rx_q     <= rx_d;
               bitcnt_q <= bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7)
                  done_q <= 1'b1;
            end
            if (sck_fall) begin
               if (load_pend_q) begin
                  tx_q        <= reply_d;
                  load_pend_q <= 1'b0;
               end else begin
                  tx_q <= {tx_q[6:0], 1'b0};
               end
            end
            // reply for this byte is picked up on the next falling edge
            if (done_q) begin
               load_pend_q <= 1'b1;
               case (state_q)
                  TARGET: begin
                     tgt_q   <= tgt_d;
                     state_q <= CMD;
                  end
                  default: begin
                     state_q <= DATA;
                     if (tgt_q != TGT_NONE) begin
                        strobe_q[tgt_q[1:0]] <= 1'b1;
                        start_q              <= (state_q == CMD);
                        dout_q               <= rx_q;
                     end
                  end
               endcase
            end
         end
      end
   end

   assign spi_io_dout    = tx_q[7];
   assign mcu_sys_strobe = strobe_q[0];
   assign mcu_hid_strobe = strobe_q[1];
   assign mcu_osd_strobe = strobe_q[2];
   assign mcu_sdc_strobe = strobe_q[3];
   assign mcu_start      = start_q;
   assign mcu_dout       = dout_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_mcu_spi_link.sv
// Bench for mcu_spi_link: an MCU-side SPI master model drives frames from a table,
// a strobe scoreboard checks routing/data, and MISO is checked per byte.
module tb_mcu_spi_link;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       spi_ss = 1'b1, spi_clk = 1'b0, spi_din = 1'b0;
   logic       spi_dout;
   logic       sys_stb, hid_stb, osd_stb, sdc_stb, start;
   logic [7:0] mdout;
   logic [7:0] sys_din = 8'h00, hid_din = 8'h00, osd_din = 8'h00, sdc_din = 8'h00;
   logic       busy;

   always #5 clk = ~clk;

   mcu_spi_link #(.SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset),
      .spi_io_ss(spi_ss), .spi_io_clk(spi_clk), .spi_io_din(spi_din), .spi_io_dout(spi_dout),
      .mcu_sys_strobe(sys_stb), .mcu_hid_strobe(hid_stb),
      .mcu_osd_strobe(osd_stb), .mcu_sdc_strobe(sdc_stb),
      .mcu_start(start), .mcu_dout(mdout),
      .mcu_sys_din(sys_din), .mcu_hid_din(hid_din),
      .mcu_osd_din(osd_din), .mcu_sdc_din(sdc_din),
      .busy(busy)
   );

   typedef struct {
      logic [7:0] mosi;
      logic [7:0] reply;
      logic [7:0] miso;
      logic [2:0] tgt;
      logic       stb;
      logic       st;
      logic       first;
      logic       last;
   } vec_t;

   typedef struct {
      logic [2:0] tgt;
      logic       st;
      logic [7:0] data;
   } exp_t;

   exp_t sbq[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   half  = 6;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wclk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic xfer(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
      miso = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         spi_din = mosi[7-i];
         wclk(half);
         miso = {miso[6:0], spi_dout};
         spi_clk = 1'b1;
         wclk(half);
         spi_clk = 1'b0;
      end
   endtask

   task automatic frame_start();
      spi_ss = 1'b0;
      wclk(half + 2);
   endtask

   task automatic frame_end();
      wclk(half);
      spi_ss = 1'b1;
      wclk(half + 4);
   endtask

   task automatic set_reply(input logic [2:0] t, input logic [7:0] v);
      sys_din = (t == 3'd0 || t == 3'd4) ? v : 8'hFF;
      hid_din = (t == 3'd1 || t == 3'd4) ? v : 8'hFF;
      osd_din = (t == 3'd2 || t == 3'd4) ? v : 8'hFF;
      sdc_din = (t == 3'd3 || t == 3'd4) ? v : 8'hFF;
   endtask

   task automatic push(input logic [2:0] t, input logic s, input logic [7:0] d);
      exp_t e;
      e.tgt = t; e.st = s; e.data = d;
      sbq.push_back(e);
   endtask

   // strobe scoreboard
   initial begin
      exp_t       e;
      logic [3:0] v;
      forever begin
         @(negedge clk);
         v = {sdc_stb, osd_stb, hid_stb, sys_stb};
         if (v != 4'b0000) begin
            if (sbq.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_strobe: got strobes %b dout %h expected none", v, mdout);
            end else begin
               e = sbq.pop_front();
               check("strobe_sel", {28'd0, v}, 32'd1 << e.tgt[1:0]);
               check("strobe_start", {31'd0, start}, {31'd0, e.st});
               check("strobe_data", {24'd0, mdout}, {24'd0, e.data});
            end
         end
      end
   end

   initial begin
      vec_t       tbl[12];
      logic [7:0] m, rep, mo;

      tbl[0]  = '{8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[1]  = '{8'h00, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{8'hAA, 8'h5C, 8'h5C, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{8'hBB, 8'h42, 8'h42, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[4]  = '{8'h07, 8'h77, 8'h00, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{8'h11, 8'h77, 8'h00, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{8'h22, 8'h77, 8'h00, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{8'h33, 8'h77, 8'h00, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[8]  = '{8'h02, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[9]  = '{8'h10, 8'h00, 8'h00, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{8'h20, 8'h9A, 8'h9A, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{8'h30, 8'h01, 8'h01, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1};

      // reset state
      wclk(3);
      check("reset_outputs", {20'd0, sys_stb, hid_stb, osd_stb, sdc_stb, start, busy, spi_dout, mdout},
            32'd0);
      reset = 1'b0;
      wclk(4);
      check("idle_outputs", {25'd0, sys_stb, hid_stb, osd_stb, sdc_stb, start, busy, spi_dout}, 32'd0);

      // table-driven frames: sys, unknown target, osd
      for (int i = 0; i < 12; i++) begin
         if (tbl[i].first) frame_start();
         set_reply(tbl[i].tgt, tbl[i].reply);
         if (tbl[i].stb) push(tbl[i].tgt, tbl[i].st, tbl[i].mosi);
         xfer(tbl[i].mosi, 8, m);
         check($sformatf("miso_row%0d", i), {24'd0, m}, {24'd0, tbl[i].miso});
         check($sformatf("busy_row%0d", i), {31'd0, busy}, 32'd1);
         if (tbl[i].last) begin
            frame_end();
            check($sformatf("end_idle_row%0d", i), {30'd0, busy, spi_dout}, 32'd0);
         end
      end

      // abort after 5 bits of byte 3, then a clean hid frame
      frame_start();
      set_reply(3'd2, 8'h00);
      xfer(8'h02, 8, m);
      push(3'd2, 1'b1, 8'h44);
      xfer(8'h44, 8, m);
      set_reply(3'd2, 8'hF0);
      xfer(8'hC3, 5, m);
      check("abort_partial_miso", {24'd0, m}, 32'h1E);
      frame_end();
      check("abort_idle", {30'd0, busy, spi_dout}, 32'd0);
      frame_start();
      set_reply(3'd1, 8'h00);
      xfer(8'h01, 8, m);
      push(3'd1, 1'b1, 8'h03);
      xfer(8'h03, 8, m);
      check("hid_cmd_miso", {24'd0, m}, 32'd0);
      frame_end();

      // async reset during the cmd byte; rest of frame must be ignored
      frame_start();
      set_reply(3'd0, 8'h00);
      xfer(8'h00, 8, m);
      xfer(8'h5A, 4, m);
      reset = 1'b1;
      #1;
      check("reset_midframe", {20'd0, sys_stb, hid_stb, osd_stb, sdc_stb, start, busy, spi_dout, mdout},
            32'd0);
      wclk(2);
      reset = 1'b0;
      xfer(8'hA5, 4, m);
      xfer(8'h11, 8, m);
      check("post_reset_busy", {31'd0, busy}, 32'd0);
      xfer(8'h22, 8, m);
      check("post_reset_miso", {24'd0, m}, 32'd0);
      frame_end();
      frame_start();
      push(3'd0, 1'b1, 8'h5A);
      xfer(8'h00, 8, m);
      xfer(8'h5A, 8, m);
      push(3'd0, 1'b0, 8'h6B);
      xfer(8'h6B, 8, m);
      frame_end();

      // minimum SCK half-period, 16 bytes to sdc after the target byte
      half = 5;
      frame_start();
      for (int k = 0; k < 17; k++) begin
         mo  = (k == 0) ? 8'h03 : 8'(k * 37 + 11);
         rep = 8'($urandom_range(0, 255));
         set_reply(3'd3, rep);
         if (k >= 1) push(3'd3, (k == 1), mo);
         xfer(mo, 8, m);
         check($sformatf("sdc_miso%0d", k), {24'd0, m}, (k >= 2) ? {24'd0, rep} : 32'd0);
      end
      frame_end();

      wclk(10);
      check("scoreboard_drained", sbq.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
